// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array and its frame sequencer.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package systolic_pkg;

  // Sequencer phases: wait for start, stream samples, flush with zeros, report end of frame.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Defaults kept in one place so the array and the sequencer agree on geometry.
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_CELL_COUNT = 3;
  localparam int DEF_KERNEL_LEN = 12;

endpackage

// File: rtl/ce_tag_pipe.sv
// Enable-gated 1-bit shift register marking which array outputs carry real samples.
// Latency: a tag leaves DEPTH ce-cycles after it enters; result_vld is combinational on ce.
// Backpressure: none; the pipe freezes whenever ce is low, exactly like the array.
module ce_tag_pipe
  import systolic_pkg::*;
#(
  parameter int DEPTH = DEF_CELL_COUNT
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic tag_in,
  output logic result_vld
);

  logic [DEPTH-1:0] tags;

  // Advance the tags only on array ce-cycles so they stay aligned with the cell pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      tags <= '0;
    end else if (ce) begin
      tags <= (tags << 1) | DEPTH'(tag_in);
    end
  end

  // The bit leaving the last stage on a ce-cycle says whether arr_y_out holds a real result.
  assign result_vld = ce & tags[DEPTH-1];

endmodule

// File: rtl/systolic_array_sequencer.sv
// Frame controller: streams frame_len samples into the array, flushes CELL_COUNT zeros, emits tagged results.
// Latency: accept -> arr_x_in next cycle; result on m_data one cycle after the ce-cycle CELL_COUNT ce-cycles later.
// Backpressure: s_ready high only in RUN; input stalls freeze the array (no bubbles); m_valid cannot be stalled.
module systolic_array_sequencer
  import systolic_pkg::*;
#(
  parameter int WIDTH               = DEF_WIDTH,
  parameter int CELL_COUNT          = DEF_CELL_COUNT,
  parameter int CELL_MEM_ADDR_WIDTH = 4,
  parameter int KERNEL_LEN          = DEF_KERNEL_LEN,
  parameter int LEN_WIDTH           = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [LEN_WIDTH-1:0]           frame_len,
  input  logic [31:0]                    cfg_ctrl,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [WIDTH-1:0]               s_data,
  output logic                           arr_ce,
  output logic [31:0]                    arr_ctrl,
  output logic [CELL_MEM_ADDR_WIDTH-1:0] arr_mem_addr,
  output logic [WIDTH-1:0]               arr_x_in,
  input  logic [WIDTH-1:0]               arr_y_out,
  output logic                           m_valid,
  output logic [WIDTH-1:0]               m_data,
  output logic                           busy,
  output logic                           done
);

  localparam int DCW = $clog2(CELL_COUNT + 1);
  localparam logic [CELL_MEM_ADDR_WIDTH-1:0] ADDR_LAST = CELL_MEM_ADDR_WIDTH'(KERNEL_LEN - 1);

  seq_state_t                     state, next_state;
  logic [LEN_WIDTH-1:0]           len_q;
  logic [LEN_WIDTH-1:0]           cnt;
  logic [DCW-1:0]                 drain_cnt;
  logic [CELL_MEM_ADDR_WIDTH-1:0] addr;
  logic [CELL_MEM_ADDR_WIDTH-1:0] addr_next;
  logic                           tag_q;
  logic                           result_vld;
  logic                           start_frame;
  logic                           start_empty;
  logic                           accept;
  logic                           drain_issue;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and per-cycle strobes; start is only honoured in IDLE.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    start_empty = 1'b0;
    accept      = 1'b0;
    drain_issue = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            start_frame = 1'b1;
            next_state  = ST_RUN;
          end else begin
            start_empty = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (s_valid) begin
          accept = 1'b1;
          if (cnt == len_q - LEN_WIDTH'(1)) begin
            next_state = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DCW'(CELL_COUNT)) begin
          next_state = ST_DONE;
        end else begin
          drain_issue = 1'b1;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  assign s_ready   = (state == ST_RUN);
  assign busy      = (state == ST_RUN) || (state == ST_DRAIN);
  assign addr_next = (addr == ADDR_LAST) ? '0 : addr + CELL_MEM_ADDR_WIDTH'(1);

  // Registered array drive: one ce-cycle per accepted sample or flush slot, frozen otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q        <= '0;
      cnt          <= '0;
      drain_cnt    <= '0;
      addr         <= '0;
      tag_q        <= 1'b0;
      arr_ce       <= 1'b0;
      arr_ctrl     <= '0;
      arr_mem_addr <= '0;
      arr_x_in     <= '0;
      m_valid      <= 1'b0;
      m_data       <= '0;
      done         <= 1'b0;
    end else begin
      arr_ce  <= accept | drain_issue;
      done    <= start_empty | (next_state == ST_DONE);
      m_valid <= result_vld;
      if (result_vld) begin
        m_data <= arr_y_out;
      end
      if (start_frame) begin
        len_q     <= frame_len;
        arr_ctrl  <= cfg_ctrl;
        cnt       <= '0;
        drain_cnt <= '0;
        addr      <= '0;
      end
      if (accept) begin
        arr_x_in     <= s_data;
        arr_mem_addr <= addr;
        addr         <= addr_next;
        cnt          <= cnt + LEN_WIDTH'(1);
        tag_q        <= 1'b1;
      end
      if (drain_issue) begin
        arr_x_in     <= '0;
        arr_mem_addr <= addr;
        addr         <= addr_next;
        drain_cnt    <= drain_cnt + DCW'(1);
        tag_q        <= 1'b0;
      end
      if (next_state == ST_DONE) begin
        arr_ctrl     <= '0;
        arr_mem_addr <= '0;
        arr_x_in     <= '0;
      end
    end
  end

  ce_tag_pipe #(
    .DEPTH(CELL_COUNT)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .ce        (arr_ce),
    .tag_in    (tag_q),
    .result_vld(result_vld)
  );

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Bench for systolic_array_sequencer: two instances (KERNEL_LEN 12 and 16) share stimulus.
// A behavioural array drives arr_y_out; expectations come from per-sample arithmetic.
// Random data, random stalls and directed frames from the test plan.
module tb_systolic_array_sequencer;

  localparam int W  = 8;
  localparam int C  = 3;
  localparam int AW = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic [31:0]   cfg_ctrl = '0;
  logic [W-1:0]  s_data = '0;

  logic          s_ready [2];
  logic          arr_ce [2];
  logic          m_valid [2];
  logic          busy [2];
  logic          done [2];
  logic [31:0]   arr_ctrl [2];
  logic [AW-1:0] arr_mem_addr [2];
  logic [W-1:0]  arr_x_in [2];
  logic [W-1:0]  arr_y_out [2];
  logic [W-1:0]  m_data [2];
  logic [W-1:0]  pipe [2][C];

  int n_cmp = 0;
  int n_bad = 0;

  // Frame reference shared with the monitor.
  int            N = 0;
  logic [31:0]   ctrl_ref = '0;
  logic [W-1:0]  smp[$];
  bit            mon_en = 1'b0;
  bit            mon_clr = 1'b0;

  int ce_idx [2];
  int res_idx [2];
  int done_cnt [2];
  bit prev_acc [2];
  bit prev_ce [2];

  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    systolic_array_sequencer #(
      .WIDTH(W), .CELL_COUNT(C), .CELL_MEM_ADDR_WIDTH(AW),
      .KERNEL_LEN(g == 0 ? 12 : 16), .LEN_WIDTH(LW)
    ) dut (
      .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .cfg_ctrl(cfg_ctrl),
      .s_valid(s_valid), .s_ready(s_ready[g]), .s_data(s_data),
      .arr_ce(arr_ce[g]), .arr_ctrl(arr_ctrl[g]), .arr_mem_addr(arr_mem_addr[g]),
      .arr_x_in(arr_x_in[g]), .arr_y_out(arr_y_out[g]),
      .m_valid(m_valid[g]), .m_data(m_data[g]), .busy(busy[g]), .done(done[g])
    );
    assign arr_y_out[g] = pipe[g][C-1];
  end

  always #5 clk = ~clk;

  function automatic int klen(input int d);
    return (d == 0) ? 12 : 16;
  endfunction

  // What one array pass does to a sample: weight from ROM address plus control offset.
  function automatic logic [W-1:0] model_y(input logic [W-1:0] x, input int addr, input logic [31:0] ctrl);
    logic [W-1:0] rom;
    rom = W'(addr * 37 + 5);
    return x + rom + ctrl[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural array: C-deep pipeline advancing only on ce.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = 0; i < C; i++) pipe[d][i] <= '0;
      end else if (arr_ce[d]) begin
        pipe[d][0] <= model_y(arr_x_in[d], int'(arr_mem_addr[d]), arr_ctrl[d]);
        for (int i = 1; i < C; i++) pipe[d][i] <= pipe[d][i-1];
      end
    end
  end

  // Monitor: every ce-cycle and every result is checked against the frame reference.
  initial begin
    forever begin
      @(negedge clk);
      if (rst || mon_clr) begin
        for (int d = 0; d < 2; d++) begin
          ce_idx[d] = 0; res_idx[d] = 0; done_cnt[d] = 0;
          prev_acc[d] = 1'b0; prev_ce[d] = 1'b0;
        end
      end else if (mon_en) begin
        for (int d = 0; d < 2; d++) begin
          int ct;
          ct = (N == 0) ? 0 : N + C;
          if (prev_acc[d]) chk("ce_follows_accept", 32'(arr_ce[d]), 32'd1);
          if (arr_ce[d]) begin
            if (ce_idx[d] < N) chk("ce_without_accept", 32'(prev_acc[d]), 32'd1);
            if (ce_idx[d] < ct) begin
              chk("mem_addr", 32'(arr_mem_addr[d]), 32'(ce_idx[d] % klen(d)));
              chk("x_in", 32'(arr_x_in[d]), (ce_idx[d] < N) ? 32'(smp[ce_idx[d]]) : 32'd0);
              chk("arr_ctrl", arr_ctrl[d], ctrl_ref);
            end else begin
              chk("ce_count", 32'(ce_idx[d] + 1), 32'(ct));
            end
            ce_idx[d]++;
          end
          if (m_valid[d]) begin
            if (res_idx[d] < N)
              chk("m_data", 32'(m_data[d]), 32'(model_y(smp[res_idx[d]], res_idx[d] % klen(d), ctrl_ref)));
            else
              chk("m_valid_count", 32'(res_idx[d] + 1), 32'(N));
            res_idx[d]++;
          end
          if (done[d]) begin
            done_cnt[d]++;
            chk("results_by_done", 32'(res_idx[d]), 32'(N));
            chk("ce_total_at_done", 32'(ce_idx[d]), 32'(ct));
            chk("done_ctrl_zero", arr_ctrl[d], 32'd0);
            chk("done_ce_zero", 32'(arr_ce[d]), 32'd0);
            if (N > 0) chk("done_after_last_ce", 32'(prev_ce[d]), 32'd1);
          end
          prev_acc[d] = s_valid && s_ready[d];
          prev_ce[d]  = arr_ce[d];
        end
      end
    end
  end

  task automatic chk_idle(input string pfx);
    for (int d = 0; d < 2; d++) begin
      chk({pfx, "_s_ready"}, 32'(s_ready[d]), 32'd0);
      chk({pfx, "_arr_ce"}, 32'(arr_ce[d]), 32'd0);
      chk({pfx, "_arr_ctrl"}, arr_ctrl[d], 32'd0);
      chk({pfx, "_mem_addr"}, 32'(arr_mem_addr[d]), 32'd0);
      chk({pfx, "_x_in"}, 32'(arr_x_in[d]), 32'd0);
      chk({pfx, "_m_valid"}, 32'(m_valid[d]), 32'd0);
      chk({pfx, "_m_data"}, 32'(m_data[d]), 32'd0);
      chk({pfx, "_busy"}, 32'(busy[d]), 32'd0);
      chk({pfx, "_done"}, 32'(done[d]), 32'd0);
    end
  endtask

  // mode 0: continuous, 1: fixed stall pattern, 2: random stalls. poke: start mid-frame.
  task automatic run_frame(input int n, input int mode, input bit poke);
    int i;
    int cyc;
    bit acc;
    logic [31:0] c;
    c = $urandom;
    @(posedge clk); #1;
    N = n; ctrl_ref = c; mon_clr = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;
    mon_clr = 1'b0; start = 1'b1; frame_len = LW'(n); cfg_ctrl = c;
    @(posedge clk); #1;
    start = 1'b0; frame_len = LW'($urandom); cfg_ctrl = $urandom;
    i = 0; cyc = 0;
    while (i < n && cyc < 8 * n + 20) begin
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (cyc < 7) ? pat[cyc] : 1'b1;
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = smp[i];
      if (poke && i == 1) begin
        start = 1'b1; frame_len = LW'(7);
      end
      acc = s_valid && s_ready[0];
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) i++;
      cyc++;
    end
    if (i < n) chk("feed_timeout", 32'(i), 32'(n));
    cyc = 0;
    while (!done[0] && cyc < 40) begin
      s_valid = 1'($urandom_range(0, 1)); s_data = W'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", 32'(done[0]), 32'd1);
    if (n > 0) begin
      start = 1'b1; frame_len = LW'(5);
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int d = 0; d < 2; d++) chk("start_in_done_ignored", 32'(busy[d]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("done_pulses", 32'(done_cnt[d]), 32'd1);
      chk("result_count", 32'(res_idx[d]), 32'(n));
    end
    s_valid = 1'b0; mon_en = 1'b0;
  endtask

  task automatic fill_random(input int n);
    smp.delete();
    for (int k = 0; k < n; k++) smp.push_back(W'($urandom));
  endtask

  initial begin
    int seen;
    logic [W-1:0] d16 [16];
    d16 = '{8'd0, 8'd1, 8'd0, 8'd2, 8'd5, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd11, 8'd0, 8'd0, 8'd6};

    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    rst = 1'b0;

    // Reset mid-frame after two accepted samples.
    @(posedge clk); #1;
    start = 1'b1; frame_len = LW'(5); cfg_ctrl = $urandom;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; s_data = W'($urandom);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle("mid_reset");
    rst = 1'b0; s_valid = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done[0] || done[1]) seen++;
    end
    chk("no_done_after_reset", 32'(seen), 32'd0);
    fill_random(5);
    run_frame(5, 0, 1'b0);

    // Sixteen-sample frame with the listed data.
    smp.delete();
    for (int k = 0; k < 16; k++) smp.push_back(d16[k]);
    run_frame(16, 0, 1'b0);

    // Stalled frame, then the same samples unstalled.
    fill_random(4);
    run_frame(4, 1, 1'b0);
    run_frame(4, 0, 1'b0);

    // Zero-length frame, then a start poked mid-frame.
    smp.delete();
    run_frame(0, 0, 1'b0);
    fill_random(3);
    run_frame(3, 0, 1'b1);

    // Address wrap on both kernel lengths.
    fill_random(20);
    run_frame(20, 0, 1'b0);

    // Random frames with random stalls.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 24);
      fill_random(n);
      run_frame(n, 2, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit reached");
  end

endmodule
